// File: rtl/line_fill_buffer.sv
// Critical-word-first line fill buffer: collects N beats of w bits into one
// flat line register, tracking per-word validity and flagging the first beat.
module line_fill_buffer #(
    parameter int SEL_WIDTH = 4,
    parameter int w         = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [SEL_WIDTH-1:0]            start_word,
    input  logic                            mem_valid,
    input  logic [w-1:0]                    mem_data,
    output logic                            mem_ready,
    output logic [(1<<SEL_WIDTH)*w-1:0]     line_out,
    output logic [(1<<SEL_WIDTH)-1:0]       word_valid,
    output logic                            crit_valid,
    output logic [w-1:0]                    crit_data,
    output logic                            line_valid,
    input  logic                            line_ack,
    output logic                            busy
);

    localparam int N = 1 << SEL_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0] cnt_q, cnt_d;
    logic [N-1:0]         word_valid_q, word_valid_d;
    logic [w-1:0]         crit_data_q, crit_data_d;
    logic                 crit_valid_q, crit_valid_d;
    logic                 beat_acc;

    // Handshake outputs decode from state alone so no input reaches them combinationally.
    assign mem_ready  = (state_q == FILL);
    assign line_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign beat_acc   = mem_valid && (state_q == FILL);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        word_valid_d = word_valid_q;
        crit_data_d  = crit_data_q;
        crit_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d        = start_word;
                    cnt_d        = '0;
                    word_valid_d = '0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                if (beat_acc) begin
                    word_valid_d[ptr_q] = 1'b1;
                    ptr_d               = ptr_q + SEL_WIDTH'(1);
                    cnt_d               = cnt_q + SEL_WIDTH'(1);
                    if (cnt_q == '0) begin
                        crit_data_d  = mem_data;
                        crit_valid_d = 1'b1;
                    end
                    if (&cnt_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (line_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            word_valid_q <= '0;
            crit_data_q  <= '0;
            crit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            word_valid_q <= word_valid_d;
            crit_data_q  <= crit_data_d;
            crit_valid_q <= crit_valid_d;
        end
    end

    // One register per word; it only loads when the write pointer selects it,
    // so old contents persist across IDLE until overwritten by the next fill.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_word
            logic [w-1:0] word_q, word_d;

            always_comb begin
                word_d = word_q;
                if (beat_acc && (ptr_q == SEL_WIDTH'(gi))) begin
                    word_d = mem_data;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign line_out[gi*w +: w] = word_q;
        end
    endgenerate

    assign word_valid = word_valid_q;
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;

endmodule
